// File: rtl/rx_pkt_head_buffer_pkg.sv
// Shared definitions for the RX packet-head ingress buffer: meta bus width,
// opcode field position and the opcodes the downstream dispatcher supports.
package rx_pkt_head_buffer_pkg;

    localparam int PKT_META_BUS_WIDTH = 64;

    // Opcode field position inside a packet meta head (single definition for screen and dispatcher)
    localparam int OPCODE_MSB = 28;
    localparam int OPCODE_LSB = 24;
    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

    typedef enum logic [OPCODE_W-1:0] {
        SEND_FIRST                    = 5'h00,
        SEND_MIDDLE                   = 5'h01,
        SEND_LAST                     = 5'h02,
        SEND_LAST_WITH_IMM            = 5'h03,
        SEND_ONLY                     = 5'h04,
        SEND_ONLY_WITH_IMM            = 5'h05,
        RDMA_WRITE_FIRST              = 5'h06,
        RDMA_WRITE_MIDDLE             = 5'h07,
        RDMA_WRITE_LAST               = 5'h08,
        RDMA_WRITE_LAST_WITH_IMM      = 5'h09,
        RDMA_WRITE_ONLY               = 5'h0A,
        RDMA_WRITE_ONLY_WITH_IMM      = 5'h0B,
        RDMA_READ_REQUEST_FIRST       = 5'h0C,
        RDMA_READ_REQUEST_MIDDLE      = 5'h0D,
        RDMA_READ_REQUEST_LAST        = 5'h0E,
        RDMA_READ_REQUEST_ONLY        = 5'h0F,
        RDMA_READ_RESPONSE_FIRST      = 5'h10,
        RDMA_READ_RESPONSE_MIDDLE     = 5'h11,
        RDMA_READ_RESPONSE_LAST       = 5'h12,
        RDMA_READ_RESPONSE_ONLY       = 5'h13,
        ACKNOWLEDGE                   = 5'h14
    } opcode_e;

    // True for every opcode the dispatcher can consume without stalling
    function automatic logic isLegalOpcode(input logic [OPCODE_W-1:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            SEND_FIRST, SEND_MIDDLE, SEND_LAST, SEND_LAST_WITH_IMM, SEND_ONLY, SEND_ONLY_WITH_IMM,
            RDMA_WRITE_FIRST, RDMA_WRITE_MIDDLE, RDMA_WRITE_LAST, RDMA_WRITE_LAST_WITH_IMM,
            RDMA_WRITE_ONLY, RDMA_WRITE_ONLY_WITH_IMM,
            RDMA_READ_REQUEST_FIRST, RDMA_READ_REQUEST_MIDDLE, RDMA_READ_REQUEST_LAST,
            RDMA_READ_REQUEST_ONLY,
            RDMA_READ_RESPONSE_FIRST, RDMA_READ_RESPONSE_MIDDLE, RDMA_READ_RESPONSE_LAST,
            RDMA_READ_RESPONSE_ONLY,
            ACKNOWLEDGE: legal = 1'b1;
            default:     legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/rx_head_fifo.sv
// Generic first-word-fall-through synchronous FIFO. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a separate counter.
module rx_head_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [WIDTH-1:0]         o_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wrPtr == r_rdPtr);
    assign o_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign o_count = r_wrPtr - r_rdPtr;
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = o_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];

    // Storage array needs no reset: an empty FIFO masks its contents to zero
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr[AW-1:0]] <= i_data;
        end
    end

    // Read and write pointers advance independently; reset discards everything buffered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/rx_pkt_head_buffer.sv
// Ingress head buffer in front of the RX dispatcher. Heads with opcodes the
// dispatcher cannot handle are swallowed here and counted, so they can never
// wedge the dispatcher; legal heads are queued and presented FWFT.
module rx_pkt_head_buffer
    import rx_pkt_head_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          net_pkt_valid,
    input  logic [PKT_META_BUS_WIDTH-1:0] net_pkt_head,
    output logic                          net_pkt_ready,
    output logic                          ingress_pkt_valid,
    output logic [PKT_META_BUS_WIDTH-1:0] ingress_pkt_head,
    input  logic                          ingress_pkt_ready,
    input  logic                          drop_cnt_clr,
    output logic [CNT_W-1:0]              drop_cnt,
    output logic [$clog2(DEPTH):0]        fifo_occupancy
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             r_outOfReset;
    logic [CNT_W-1:0] r_dropCnt;
    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic             w_legal;
    logic             w_push;
    logic             w_drop;
    logic             w_pop;

    // Ready depends only on registered state so the parser never sees a combinational loop
    assign net_pkt_ready     = r_outOfReset & ~w_full;
    assign w_accept          = net_pkt_valid & net_pkt_ready;
    assign w_legal           = isLegalOpcode(net_pkt_head[OPCODE_MSB:OPCODE_LSB]);
    assign w_push            = w_accept & w_legal;
    assign w_drop            = w_accept & ~w_legal;
    assign ingress_pkt_valid = ~w_empty;
    assign w_pop             = ingress_pkt_valid & ingress_pkt_ready;
    assign drop_cnt          = r_dropCnt;

    rx_head_fifo #(
        .WIDTH (PKT_META_BUS_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (net_pkt_head),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_occupancy),
        .o_data  (ingress_pkt_head)
    );

    // Holds ready low until the first clock edge after reset is released
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_outOfReset <= 1'b0;
        end else begin
            r_outOfReset <= 1'b1;
        end
    end

    // Saturating drop counter; a clear wins but still counts a drop in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dropCnt <= '0;
        end else if (drop_cnt_clr) begin
            r_dropCnt <= w_drop ? CNT_ONE : '0;
        end else if (w_drop && (r_dropCnt != CNT_MAX)) begin
            r_dropCnt <= r_dropCnt + CNT_ONE;
        end
    end

endmodule
